mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single slow main-memory port between the I-cache and D-cache line refill/writeback engines of the RISC-V pipeline core.
- Fixed priority goes to the D-cache, because a D-cache miss stalls all of IF/ID/EX/MEM/WB.
- A starvation counter forces an I-cache grant after STARVE_LIMIT consecutive D grants made while the I-cache was waiting.
- It has one outstanding memory transaction at a time, with registered command outputs and a registered single-cycle ready pulse back to each cache.

Parameters:
- ADDR_W, 28: line address width (byte address [31:4]).
- DATA_W, 128: line width in bits.
- STARVE_LIMIT, 4: consecutive D grants, with I pending, before I is forced; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- i_read  input  1  I-cache refill request; held until i_ready.
- i_addr  input  ADDR_W  I-cache line address; stable while i_read.
- i_rdata  output  DATA_W  refill line to I-cache; valid when i_ready.
- i_ready  output  1  one-cycle completion pulse to I-cache.
- d_read  input  1  D-cache refill request; held until d_ready.
- d_write  input  1  D-cache writeback request; held until d_ready.
- d_addr  input  ADDR_W  D-cache line address.
- d_wdata  input  DATA_W  D-cache writeback line.
- d_rdata  output  DATA_W  refill line to D-cache; valid when d_ready.
- d_ready  output  1  one-cycle completion pulse to D-cache.
- mem_read  output  1  memory read command.
- mem_write  output  1  memory write command.
- mem_addr  output  ADDR_W  memory line address.
- mem_wdata  output  DATA_W  memory write line.
- mem_rdata  input  DATA_W  memory read line; valid when mem_ready.
- mem_ready  input  1  memory completion pulse.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- States and transitions:
  - IDLE: waits for a request.
  - BUSY_I: an I-cache transaction is in flight.
  - BUSY_D: a D-cache transaction is in flight.
  - RESP: ready pulse returned. Always goes to IDLE next cycle.
- Reset (rst_n=0 at a clock edge), from any state including mid-transaction:
  - state goes to IDLE; starve counter to 0.
  - mem_read, mem_write, i_ready, d_ready and busy go to 0.
  - mem_addr, mem_wdata, i_rdata and d_rdata go to 0.
  - An in-flight memory transaction is abandoned. Memory is reset by the same rst_n.
- Arbitration in IDLE, at the clock edge:
  - d_req = d_read|d_write; i_req = i_read.
  - Both requesting and starve==STARVE_LIMIT: grant I.
  - Otherwise d_req: grant D.
  - Otherwise i_req: grant I.
  - Otherwise stay in IDLE.
- On grant, latch the command into output registers:
  - Grant D: mem_write=d_write, mem_read=d_read&~d_write (write wins if both are asserted), mem_addr=d_addr, mem_wdata=d_wdata.
  - Grant I: mem_read=1, mem_write=0, mem_addr=i_addr, mem_wdata held.
  - Commands become visible to memory the cycle after the request is first seen in IDLE (1-cycle grant latency).
- Starve counter:
  - On a D grant while i_req=1: increments, saturating at STARVE_LIMIT.
  - On a D grant while i_req=0: unchanged.
  - On any I grant: cleared to 0.
- BUSY_x:
  - Command registers are held constant.
  - Requester input changes are ignored.
  - On mem_ready=1:
    - Drop mem_read and mem_write to 0.
    - Load mem_rdata into the winner's rdata register (D writes also load it; the value is don't-care).
    - Pulse the winner's ready for exactly one cycle, in RESP.
    - Move to RESP.
  - mem_ready outside BUSY_x is ignored.
- RESP:
  - Exactly one of i_ready/d_ready is high.
  - The loser's ready stays 0.
  - Next state is IDLE.
- Requester rules:
  - A requester must deassert its request in the cycle following its ready pulse, i.e. the IDLE cycle after RESP.
  - A request still high in that cycle is treated as a new request.
- Response holding:
  - i_rdata and d_rdata hold their last value until overwritten by the next completed transaction for that requester.
- Minimum transaction time:
  - Request-to-ready is at least 3 cycles (IDLE sample, BUSY with mem_ready, RESP).
  - Back-to-back grants are separated by the RESP→IDLE cycle.
- Ready pulses:
  - i_ready and d_ready are never high simultaneously.
  - mem_read and mem_write are never high simultaneously.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid-BUSY_D with mem_ready=0. All outputs are 0, busy=0, state is IDLE; a later d_read is granted normally.
- Lone I refill: i_read=1, i_addr=0x0000010, memory returns 0xDEADBEEF_..._0001 after 5 cycles.
  - mem_read rises 1 cycle after i_read with mem_addr=0x0000010.
  - i_ready pulses 1 cycle after mem_ready with i_rdata equal to the returned line.
  - d_ready stays 0.
- Simultaneous requests: i_read=1 and d_write=1 in the same cycle, d_addr=0x0000020.
  - D is granted first: mem_write=1, mem_wdata=d_wdata.
  - After d_ready, I is granted on the next IDLE cycle.
- Starvation: hold i_read=1 and re-issue d_read immediately after each d_ready, STARVE_LIMIT=4.
  - Exactly 4 D grants occur, then the 5th grant is I.
  - The counter clears to 0, and subsequent D grants resume.
- Protocol: d_read and d_write both high produce a write only. mem_ready pulsed in IDLE produces no ready pulse and no state change. Each ready pulse is 1 cycle wide.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one main-memory port between I-cache and D-cache
// refill/writeback engines. D-cache has fixed priority, with a starvation
// counter that forces an I grant after STARVE_LIMIT consecutive D grants
// made while I was waiting. One outstanding transaction; all outputs registered.
module mem_port_arbiter #(
  parameter int ADDR_W       = 28,
  parameter int DATA_W       = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Memory command as presented on the port; held stable for the whole
  // transaction so memory sees a clean registered command.
  typedef struct packed {
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;

  logic d_req, i_req, force_i;

  assign d_req   = d_read | d_write;
  assign i_req   = i_read;
  // Starvation override only matters when D is also competing.
  assign force_i = d_req & i_req & (starve_q == STARVE_MAX);

  // Next-state, arbitration, command latch and response capture.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    cmd_d     = cmd_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (force_i || (i_req && !d_req)) begin
          state_d     = BUSY_I;
          starve_d    = '0;
          cmd_d.read  = 1'b1;
          cmd_d.write = 1'b0;
          cmd_d.addr  = i_addr;
        end else if (d_req) begin
          state_d     = BUSY_D;
          // Writeback wins if the cache asserts both.
          cmd_d.write = d_write;
          cmd_d.read  = d_read & ~d_write;
          cmd_d.addr  = d_addr;
          cmd_d.wdata = d_wdata;
          if (i_req && (starve_q != STARVE_MAX)) starve_d = starve_q + 1'b1;
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          state_d     = RESP;
          cmd_d.read  = 1'b0;
          cmd_d.write = 1'b0;
          i_rdata_d   = mem_rdata;
          i_ready_d   = 1'b1;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          state_d     = RESP;
          cmd_d.read  = 1'b0;
          cmd_d.write = 1'b0;
          d_rdata_d   = mem_rdata;
          d_ready_d   = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      cmd_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      cmd_q     <= cmd_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
    end
  end

  assign mem_read  = cmd_q.read;
  assign mem_write = cmd_q.write;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset mid-transaction, lone I refill,
// simultaneous requests, starvation override and protocol corner cases.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_read, d_read, d_write, mem_ready;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [DATA_W-1:0] d_wdata, mem_rdata;
  logic [DATA_W-1:0] i_rdata, d_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              i_ready, d_ready, mem_read, mem_write, busy;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  localparam logic [DATA_W-1:0] LINE_I = 128'hDEADBEEF_00000000_00000000_00000001;
  localparam logic [DATA_W-1:0] LINE_D = 128'hCAFEF00D_11112222_33334444_55556666;
  localparam logic [DATA_W-1:0] WB     = 128'hA5A5A5A5_0F0F0F0F_12345678_9ABCDEF0;

  initial begin
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_i;

    rst_n = 1'b0; i_read = 0; d_read = 0; d_write = 0; mem_ready = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_mem_rd", mem_read, 0);
    chk("rst_i_ready", i_ready, 0);

    // Reset asserted mid BUSY_D.
    rst_n = 1'b1; d_read = 1; d_addr = 28'h55; d_wdata = WB;
    tick();
    chk("pre_rst_mem_rd", mem_read, 1);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0; d_read = 0;
    tick(); tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_mem_rd", mem_read, 0);
    chk("midrst_mem_wr", mem_write, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_mem_wdata", mem_wdata, 0);
    chk("midrst_readies", {i_ready, d_ready}, 0);
    chk("midrst_rdata", {i_rdata, d_rdata} == '0, 1);

    // Normal D refill after reset.
    rst_n = 1'b1; tick();
    d_read = 1; d_addr = 28'h77;
    tick();
    chk("d_grant_rd", mem_read, 1);
    chk("d_grant_addr", mem_addr, 28'h77);
    mem_ready = 1; mem_rdata = LINE_D;
    tick();
    mem_ready = 0; d_read = 0;
    chk("d_ready", d_ready, 1);
    chk("d_rdata", d_rdata, LINE_D);
    chk("d_done_mem_rd", mem_read, 0);
    tick();
    chk("d_ready_width", d_ready, 0);
    chk("d_idle", busy, 0);

    // Lone I refill, memory responds after 5 cycles.
    i_read = 1; i_addr = 28'h0000010;
    tick();
    chk("i_grant_rd", mem_read, 1);
    chk("i_grant_wr", mem_write, 0);
    chk("i_grant_addr", mem_addr, 28'h0000010);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("i_wait_ready", {i_ready, d_ready}, 0);
      chk("i_wait_busy", busy, 1);
    end
    mem_ready = 1; mem_rdata = LINE_I;
    tick();
    mem_ready = 0; i_read = 0;
    chk("i_ready", i_ready, 1);
    chk("i_no_d_ready", d_ready, 0);
    chk("i_rdata", i_rdata, LINE_I);
    tick();
    chk("i_ready_width", i_ready, 0);
    chk("d_rdata_held", d_rdata, LINE_D);

    // Simultaneous I read and D write: D first.
    i_read = 1; i_addr = 28'h0000031; d_write = 1; d_addr = 28'h0000020; d_wdata = WB;
    tick();
    chk("sim_wr", mem_write, 1);
    chk("sim_rd", mem_read, 0);
    chk("sim_addr", mem_addr, 28'h0000020);
    chk("sim_wdata", mem_wdata, WB);
    mem_ready = 1; mem_rdata = '0;
    tick();
    mem_ready = 0; d_write = 0;
    chk("sim_d_ready", {i_ready, d_ready}, 2'b01);
    tick();
    chk("sim_resp_idle", busy, 0);
    tick();
    chk("sim_i_grant", {mem_read, mem_write}, 2'b10);
    chk("sim_i_addr", mem_addr, 28'h0000031);
    chk("sim_wdata_held", mem_wdata, WB);
    mem_ready = 1; mem_rdata = LINE_I ^ 128'hF;
    tick();
    mem_ready = 0; i_read = 0;
    chk("sim_i_ready", {i_ready, d_ready}, 2'b10);
    chk("sim_i_rdata", i_rdata, LINE_I ^ 128'hF);
    tick();

    // Starvation: both held; pattern D D D D I D D D D I.
    i_read = 1; i_addr = 28'h30; d_read = 1; d_addr = 28'h40;
    for (int g = 0; g < 10; g++) begin
      exp_i    = (g == 4) || (g == 9);
      exp_addr = exp_i ? 28'h30 : 28'h40;
      tick();
      chk($sformatf("starve_addr_%0d", g), mem_addr, exp_addr);
      mem_ready = 1; mem_rdata = DATA_W'(g);
      tick();
      mem_ready = 0;
      chk($sformatf("starve_ready_%0d", g), {i_ready, d_ready}, exp_i ? 2'b10 : 2'b01);
      tick();
    end
    i_read = 0; d_read = 0;
    tick();
    chk("starve_done_idle", busy, 0);

    // D read and write together -> write only.
    d_read = 1; d_write = 1; d_addr = 28'h99; d_wdata = LINE_D;
    tick();
    chk("rw_both", {mem_read, mem_write}, 2'b01);
    mem_ready = 1;
    tick();
    mem_ready = 0; d_read = 0; d_write = 0;
    chk("rw_ready", d_ready, 1);
    tick();

    // mem_ready in IDLE is ignored.
    mem_ready = 1; mem_rdata = '1;
    tick();
    mem_ready = 0;
    chk("idle_mr_busy", busy, 0);
    chk("idle_mr_ready", {i_ready, d_ready}, 0);
    tick();
    chk("idle_mr_ready2", {i_ready, d_ready}, 0);
    chk("idle_mr_i_rdata", i_rdata, 128'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
